uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_transmitter.sv | 170 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and default oversampling.
// Used by both the transmitter and the oversampling receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..OVERSAMPLE-1 while enabled and flags the last
// cycle of each bit period with bit_end.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] cnt;
  logic          at_max;

  assign at_max  = (cnt == CW'(OVERSAMPLE - 1));
  assign bit_end = enable && at_max;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (at_max) cnt <= '0;
      else        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with one-byte holding register; each bit lasts
// OVERSAMPLE clocks. Define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       start,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BIDX_W = $clog2(UART_DATA_BITS);

  uart_state_e       state, state_next;
  logic [7:0]        shift;
  logic [7:0]        hold;
  logic              full;
  logic [BIDX_W-1:0] bit_idx;
  logic              bit_end;
  logic              frame_end;
  logic              tx_d;
  logic              busy_d;

  logic accept;
  logic stop_end;
  logic last_data;
  logic load_from_hold;
  logic load_from_din;
  logic hold_load;

`ifdef UART_TX_PARITY_EN
  logic par;
`endif

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  assign ready = ~full;

  // A byte accepted on the very edge a stop bit ends (holding empty) goes
  // straight to the shifter so the next frame starts without parking in IDLE.
  always_comb begin
    accept         = start && !full;
    stop_end       = (state == STOP) && bit_end;
    last_data      = (state == DATA) && bit_end && (bit_idx == BIDX_W'(UART_DATA_BITS - 1));
    load_from_hold = full && ((state == IDLE) || stop_end);
    load_from_din  = accept && ((state == IDLE) || stop_end);
    hold_load      = accept && !load_from_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (full || accept) state_next = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
`ifdef UART_TX_PARITY_EN
        if (last_data) state_next = PARITY;
`else
        if (last_data) state_next = STOP;
`endif
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = (full || accept) ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift   <= '0;
      hold    <= '0;
      full    <= 1'b0;
      bit_idx <= '0;
    end else begin
      if (load_from_hold) begin
        shift   <= hold;
        bit_idx <= '0;
      end else if (load_from_din) begin
        shift   <= din;
        bit_idx <= '0;
      end else if ((state == DATA) && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + BIDX_W'(1);
      end

      if (hold_load) begin
        hold <= din;
        full <= 1'b1;
      end else if (load_from_hold) begin
        full <= 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (load_from_hold) begin
      par <= ^hold;
    end else if (load_from_din) begin
      par <= ^din;
    end
  end
`endif

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state != IDLE);
    unique case (state)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par;
`else
      PARITY: tx_d = 1'b1;
`endif
      STOP:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Outputs lag the state by one edge; done needs a second stage so it lands
  // on the same edge that the line returns to idle or begins the next start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx        <= tx_d;
      busy      <= busy_d;
      frame_end <= stop_end;
      done      <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: a frame-level reference model predicts
// acceptance, frame start times and done pulses; a monitor decodes tx.
module tb_uart_transmitter;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       start = 1'b0;
  logic       ready, tx, busy, done;

  uart_transmitter #(
    .OVERSAMPLE(OS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .start(start),
    .ready(ready),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int     done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;

  // Reference model state: end of last predicted frame and last edge the
  // holding register is still occupied.
  int last_end = 0;
  int hold_until = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
    if (FRAME == 11) f[9] = ^b;
    f[FRAME - 1] = 1'b1;
    return f;
  endfunction

  // Called at a negedge; inputs set here are sampled at edge cyc+1.
  task automatic drive_cycle(input bit s, input logic [7:0] d);
    int   e;
    int   ts;
    logic exp_ready;
    frame_t fr;
    e = cyc + 1;
    exp_ready = !(e <= hold_until);
    checks++;
    if (ready !== exp_ready) begin
      errors++;
      $display("FAIL ready edge=%0d got=%b exp=%b", e, ready, exp_ready);
    end
    start = s;
    din   = d;
    if (s && exp_ready) begin
      ts = (e + 1 > last_end) ? e + 1 : last_end;
      fr.data  = d;
      fr.start = ts;
      exp_q.push_back(fr);
      last_end = ts + FRAME * OS;
      done_q.push_back(last_end);
      hold_until = ts - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    start = 1'b0;
    exp_q.delete();
    done_q.delete();
    last_end   = 0;
    hold_until = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  logic in_frame = 1'b0;

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || in_frame) && n < limit) begin
      drive_cycle(1'b0, 8'h00);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0 || in_frame) begin
      errors++;
      $display("FAIL drain_timeout frames_left=%0d dones_left=%0d", exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
  endtask

  // Monitor / scoreboard
  int          fstart;
  int          fbad;
  logic [7:0]  fbyte;
  logic [10:0] fbits;

  always @(negedge clk) begin
    int     expd;
    logic   busy_exp;
    frame_t fr;
    int     idx;
    if (rst_seen) begin
      checks++;
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals cyc=%0d got tx=%b ready=%b busy=%b done=%b exp 1 1 0 0",
                 cyc, tx, ready, busy, done);
      end
      in_frame = 1'b0;
    end else begin
      if (done === 1'b1 || (done_q.size() != 0 && done_q[0] == cyc)) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got done=%b exp 0", cyc, done);
        end else begin
          expd = done_q.pop_front();
          if (done !== 1'b1 || expd != cyc) begin
            errors++;
            $display("FAIL done_time cyc=%0d got done=%b exp pulse at %0d", cyc, done, expd);
          end
          busy_exp = (exp_q.size() != 0 && exp_q[0].start == cyc);
          checks++;
          if (busy !== busy_exp) begin
            errors++;
            $display("FAIL busy_at_done cyc=%0d got=%b exp=%b", cyc, busy, busy_exp);
          end
        end
      end

      if (!in_frame && tx === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected cyc=%0d got start bit exp idle", cyc);
          fbyte = 8'h00;
        end else begin
          fr = exp_q.pop_front();
          fbyte = fr.data;
          if (fr.start != cyc) begin
            errors++;
            $display("FAIL frame_start byte=%h got cyc=%0d exp cyc=%0d", fr.data, cyc, fr.start);
          end
        end
        fbits    = frame_bits(fbyte);
        fstart   = cyc;
        fbad     = 0;
        in_frame = 1'b1;
      end

      if (in_frame) begin
        idx = (cyc - fstart) / OS;
        if (tx !== fbits[idx]) fbad++;
        if (cyc - fstart == FRAME * OS - 1) begin
          checks++;
          if (fbad != 0) begin
            errors++;
            $display("FAIL frame_bits byte=%h got %0d wrong tx cycles exp 0", fbyte, fbad);
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b0, 8'h00);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc=%0d got tx=%b busy=%b done=%b exp 1 0 0", cyc, tx, busy, done);
      end
    end

    drive_cycle(1'b1, 8'hA5);
    wait_idle(4 * FRAME * OS);

    drive_cycle(1'b1, 8'h07);
    wait_idle(4 * FRAME * OS);

    drive_cycle(1'b1, 8'h3C);
    repeat (40) drive_cycle(1'b0, 8'h00);
    drive_cycle(1'b1, 8'hC3);
    repeat (5) drive_cycle(1'b1, 8'hFF);
    wait_idle(4 * FRAME * OS);

    drive_cycle(1'b1, 8'h55);
    repeat (69) drive_cycle(1'b0, 8'h00);
    do_reset(1);
    repeat (3) drive_cycle(1'b0, 8'h00);
    drive_cycle(1'b1, 8'h0F);
    wait_idle(4 * FRAME * OS);

    for (int i = 0; i < 400; i++) drive_cycle(1'b1, 8'($urandom));
    wait_idle(6 * FRAME * OS);

    for (int i = 0; i < 25; i++) begin
      int gap;
      gap = $urandom_range(0, FRAME * OS + 40);
      drive_cycle(1'b1, 8'($urandom));
      for (int j = 0; j < gap; j++) drive_cycle(1'b0, 8'h00);
    end
    wait_idle(6 * FRAME * OS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
